stack_ctrl: RTL and testbench
=============================

Name: stack_ctrl

Overview:
Stack-pointer and sequencing controller for the brus16 data stack. It sits directly upstream of the `stack` distributed-SRAM block and drives that block's two async read addresses and its single write port. The core issues one stack op per cycle and sees top/next-of-stack combinationally. The block enforces depth bounds, raises sticky error flags and sequences the two-cycle SWAP.

Parameters:
WIDTH, 13, address width; must match the `stack` memory WIDTH.
SIZE, 8192, stack capacity in words; SIZE <= 2**WIDTH.

Ports:
clk  in  1  clock; all state changes on posedge.
rst_n  in  1  asynchronous active-low reset.
op_valid  in  1  op request this cycle.
op_ready  out  1  controller accepts an op; low only in SWAP2.
op  in  3  0 NOP, 1 PUSH, 2 POP, 3 BINOP, 4 DUP, 5 SWAP, 6 CLR; 7 is treated as NOP.
push_data  in  16  data for PUSH, or the ALU result for BINOP.
tos  out  16  top of stack (combinational); 0 when depth < 1.
nos  out  16  next of stack (combinational); 0 when depth < 2.
depth  out  WIDTH+1  current number of entries.
err_overflow  out  1  sticky overflow flag.
err_underflow  out  1  sticky underflow flag.
mem_dout_addr0  out  WIDTH  read address for tos = sp-1, modulo 2**WIDTH.
mem_dout0  in  16  memory read data for port 0.
mem_dout_addr1  out  WIDTH  read address for nos = sp-2, modulo 2**WIDTH.
mem_dout1  in  16  memory read data for port 1.
mem_we  out  1  memory write enable.
mem_din_addr  out  WIDTH  memory write address.
mem_din  out  16  memory write data.

Behaviour:
- Pointer: sp (WIDTH+1 bits) points to the next free slot; depth = sp.
- Reset: sp = 0, state IDLE, both error flags 0, swap latch 0, op_ready 1.
- Write port: mem_we, mem_din_addr and mem_din are combinational from op, sp and state.
- Write visibility: the memory write lands at posedge, so tos/nos reflect the write on the following cycle.
- Op accept: an op is accepted when op_valid & op_ready. Unaccepted or NOP cycles leave all state unchanged.
- PUSH: needs depth < SIZE. Writes push_data at sp; sp += 1.
- POP: needs depth >= 1. sp -= 1; no write.
- BINOP: needs depth >= 2. Writes push_data at sp-2; sp -= 1. Net effect: pop two, push one.
- DUP: needs 1 <= depth < SIZE. Writes tos at sp; sp += 1.
- SWAP: needs depth >= 2. Two-cycle sequence:
  - Cycle 1 (IDLE): writes nos at sp-1, latches the old tos, goes to SWAP2.
  - Cycle 2 (SWAP2): op_ready = 0; writes the latch at sp-2; returns to IDLE. Inputs are ignored in SWAP2.
- CLR: sp = 0 and both error flags cleared; no write. Memory contents are untouched.
- Violations:
  - A depth condition failing suppresses the write, leaves sp unchanged and keeps state IDLE.
  - PUSH, or DUP at depth == SIZE, sets err_overflow.
  - POP/BINOP/SWAP/DUP with insufficient depth sets err_underflow.
  - Flags stay set until CLR or reset. Ops continue to execute while flags are set.
- Reset mid-SWAP: asynchronous return to IDLE; the second write is lost (accepted).
- State machine: IDLE -> SWAP2 on a legal accepted SWAP; SWAP2 -> IDLE unconditionally.

Optional Feature:
STACK_CTRL_HIWATER_EN
- When defined: adds output `hiwater` (WIDTH+1 bits), the maximum depth reached since reset or CLR. It updates on the same edge as sp and resets to 0.
- When undefined: the port and register are absent; all other behaviour is identical.

Decomposition:
- Package stack_pkg holds:
  - the op enum (3-bit, encodings above);
  - the state typedef {IDLE, SWAP2};
  - localparams OP_W = 3 and DATA_W = 16.
- No sub-module. The `stack` memory is instantiated beside stack_ctrl by the enclosing core, not inside it.

Test Plan:
- PUSH 0x1111, then PUSH 0x2222 → depth 2, tos 0x2222, nos 0x1111; mem_we pulses with addr 0, then addr 1.
- From [0x1111, 0x2222], BINOP with push_data 0x3333 → write at addr 0, depth 1, tos 0x3333, nos 0.
- From [0xAAAA, 0xBBBB], SWAP → op_ready low for exactly one cycle; writes addr1 = 0xAAAA, then addr0 = 0xBBBB; afterwards tos 0xAAAA, nos 0xBBBB, depth 2.
- At depth 0, POP → err_underflow = 1, depth 0, no mem_we. Then CLR → flag = 0.
- With SIZE = 4, 5 PUSHes → 5th has no write, depth 4, err_overflow = 1. A following POP succeeds → depth 3, flag still 1.
- Assert rst_n low during SWAP2 → immediately depth 0, op_ready 1, flags 0. With STACK_CTRL_HIWATER_EN defined, hiwater = 0 after reset and 2 after two PUSHes and one POP.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types for the brus16 data-stack controller.
// Op encodings, FSM states and datapath widths.
package stack_pkg;

  localparam int OP_W   = 3;
  localparam int DATA_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 3'd0,
    OP_PUSH  = 3'd1,
    OP_POP   = 3'd2,
    OP_BINOP = 3'd3,
    OP_DUP   = 3'd4,
    OP_SWAP  = 3'd5,
    OP_CLR   = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SWAP2 = 1'b1
  } state_t;

endpackage

// File: rtl/stack_ctrl.sv
// Data-stack pointer/sequencing controller for brus16.
// Optional STACK_CTRL_HIWATER_EN adds a max-depth output.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int SIZE  = 8192
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [OP_W-1:0]   op,
  input  logic [DATA_W-1:0] push_data,
  output logic [DATA_W-1:0] tos,
  output logic [DATA_W-1:0] nos,
  output logic [WIDTH:0]    depth,
  output logic              err_overflow,
  output logic              err_underflow,
  output logic [WIDTH-1:0]  mem_dout_addr0,
  input  logic [DATA_W-1:0] mem_dout0,
  output logic [WIDTH-1:0]  mem_dout_addr1,
  input  logic [DATA_W-1:0] mem_dout1,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_din_addr,
  output logic [DATA_W-1:0] mem_din
`ifdef STACK_CTRL_HIWATER_EN
  ,
  output logic [WIDTH:0]    hiwater
`endif
);

  localparam logic [WIDTH:0] ONE    = (WIDTH+1)'(1);
  localparam logic [WIDTH:0] TWO    = (WIDTH+1)'(2);
  localparam logic [WIDTH:0] SIZE_V = (WIDTH+1)'(SIZE);

  state_t             state, state_n;
  logic [WIDTH:0]     sp, sp_n;
  logic [DATA_W-1:0]  swap_q;
  logic               swap_ld;
  logic               ovf_set, unf_set, clr;
  logic               has1, has2, full, accept;
  logic [WIDTH:0]     sp_m1, sp_m2;

  assign sp_m1  = sp - ONE;
  assign sp_m2  = sp - TWO;
  assign has1   = sp >= ONE;
  assign has2   = sp >= TWO;
  assign full   = sp >= SIZE_V;

  assign op_ready = (state == IDLE);
  assign accept   = op_valid & op_ready;
  assign depth    = sp;

  assign mem_dout_addr0 = sp_m1[WIDTH-1:0];
  assign mem_dout_addr1 = sp_m2[WIDTH-1:0];
  assign tos = has1 ? mem_dout0 : '0;
  assign nos = has2 ? mem_dout1 : '0;

  always_comb begin
    state_n      = state;
    sp_n         = sp;
    mem_we       = 1'b0;
    mem_din_addr = sp[WIDTH-1:0];
    mem_din      = push_data;
    swap_ld      = 1'b0;
    ovf_set      = 1'b0;
    unf_set      = 1'b0;
    clr          = 1'b0;
    if (state == SWAP2) begin
      // second half of SWAP: old tos lands in the nos slot
      mem_we       = 1'b1;
      mem_din_addr = sp_m2[WIDTH-1:0];
      mem_din      = swap_q;
      state_n      = IDLE;
    end else if (accept) begin
      unique case (op_e'(op))
        OP_PUSH: begin
          if (full) ovf_set = 1'b1;
          else begin
            mem_we = 1'b1;
            sp_n   = sp + ONE;
          end
        end
        OP_POP: begin
          if (!has1) unf_set = 1'b1;
          else sp_n = sp_m1;
        end
        OP_BINOP: begin
          if (!has2) unf_set = 1'b1;
          else begin
            mem_we       = 1'b1;
            mem_din_addr = sp_m2[WIDTH-1:0];
            sp_n         = sp_m1;
          end
        end
        OP_DUP: begin
          if (!has1) unf_set = 1'b1;
          else if (full) ovf_set = 1'b1;
          else begin
            mem_we  = 1'b1;
            mem_din = tos;
            sp_n    = sp + ONE;
          end
        end
        OP_SWAP: begin
          if (!has2) unf_set = 1'b1;
          else begin
            mem_we       = 1'b1;
            mem_din_addr = sp_m1[WIDTH-1:0];
            mem_din      = nos;
            swap_ld      = 1'b1;
            state_n      = SWAP2;
          end
        end
        OP_CLR: begin
          clr  = 1'b1;
          sp_n = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      sp            <= '0;
      swap_q        <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      state <= state_n;
      sp    <= sp_n;
      if (swap_ld) swap_q <= tos;
      err_overflow  <= !clr & (err_overflow | ovf_set);
      err_underflow <= !clr & (err_underflow | unf_set);
    end
  end

`ifdef STACK_CTRL_HIWATER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hiwater <= '0;
    else if (clr) hiwater <= '0;
    else if (sp_n > hiwater) hiwater <= sp_n;
  end
`endif

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed testbench for stack_ctrl with a behavioural
// stack memory beside it (async read, posedge write).
module tb_stack_ctrl;

  localparam int WIDTH = 13;
  localparam int SIZE  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op = 3'd0;
  logic [15:0] push_data = 16'h0;
  logic [15:0] tos, nos;
  logic [13:0] depth;
  logic        err_overflow, err_underflow;
  logic [12:0] mem_dout_addr0, mem_dout_addr1, mem_din_addr;
  logic [15:0] mem_dout0, mem_dout1, mem_din;
  logic        mem_we;
`ifdef STACK_CTRL_HIWATER_EN
  logic [13:0] hiwater;
`endif

  logic [15:0] mem [0:(1<<WIDTH)-1];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_dout0 = mem[mem_dout_addr0];
  assign mem_dout1 = mem[mem_dout_addr1];
  always @(posedge clk) if (mem_we) mem[mem_din_addr] <= mem_din;

  stack_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
    .clk(clk), .rst_n(rst_n),
    .op_valid(op_valid), .op_ready(op_ready),
    .op(op), .push_data(push_data),
    .tos(tos), .nos(nos), .depth(depth),
    .err_overflow(err_overflow), .err_underflow(err_underflow),
    .mem_dout_addr0(mem_dout_addr0), .mem_dout0(mem_dout0),
    .mem_dout_addr1(mem_dout_addr1), .mem_dout1(mem_dout1),
    .mem_we(mem_we), .mem_din_addr(mem_din_addr), .mem_din(mem_din)
`ifdef STACK_CTRL_HIWATER_EN
    , .hiwater(hiwater)
`endif
  );

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2,
    BINOP = 3'd3, DUP = 3'd4, SWAP = 3'd5, CLR = 3'd6;

  task automatic drive(input logic [2:0] o, input logic [15:0] d);
    @(negedge clk);
    op_valid = 1'b1;
    op = o;
    push_data = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op = NOP;
  endtask

  task automatic check_we(input string nm, input logic we,
                          input logic [12:0] a, input logic [15:0] d);
    checks++;
    if (mem_we !== we || (we && (mem_din_addr !== a || mem_din !== d))) begin
      errors++;
      $display("FAIL %s: we=%b addr=%0d din=%h, want we=%b addr=%0d din=%h",
               nm, mem_we, mem_din_addr, mem_din, we, a, d);
    end
  endtask

  task automatic check_st(input string nm, input logic [13:0] dp,
                          input logic [15:0] t, input logic [15:0] n,
                          input logic ov, input logic un);
    checks++;
    if (depth !== dp || tos !== t || nos !== n ||
        err_overflow !== ov || err_underflow !== un) begin
      errors++;
      $display("FAIL %s: depth=%0d tos=%h nos=%h ov=%b un=%b, want %0d %h %h %b %b",
               nm, depth, tos, nos, err_overflow, err_underflow, dp, t, n, ov, un);
    end
  endtask

  task automatic test_reset();
    #2;
    check_st("reset_state", 14'd0, 16'h0, 16'h0, 1'b0, 1'b0);
    checks++;
    if (op_ready !== 1'b1 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: ready=%b we=%b, want 1 0", op_ready, mem_we);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_push();
    drive(PUSH, 16'h1111);
    check_we("push1_write", 1'b1, 13'd0, 16'h1111);
    step();
    drive(PUSH, 16'h2222);
    check_we("push2_write", 1'b1, 13'd1, 16'h2222);
    step();
    check_st("push_state", 14'd2, 16'h2222, 16'h1111, 1'b0, 1'b0);
  endtask

  task automatic test_binop();
    drive(BINOP, 16'h3333);
    check_we("binop_write", 1'b1, 13'd0, 16'h3333);
    step();
    check_st("binop_state", 14'd1, 16'h3333, 16'h0, 1'b0, 1'b0);
    drive(DUP, 16'h0);
    check_we("dup_write", 1'b1, 13'd1, 16'h3333);
    step();
    check_st("dup_state", 14'd2, 16'h3333, 16'h3333, 1'b0, 1'b0);
    drive(CLR, 16'h0);
    step();
  endtask

  task automatic test_swap();
    drive(PUSH, 16'hAAAA); step();
    drive(PUSH, 16'hBBBB); step();
    drive(SWAP, 16'h0);
    check_we("swap1_write", 1'b1, 13'd1, 16'hAAAA);
    step();
    // inputs offered during SWAP2 must be ignored
    op_valid = 1'b1;
    op = PUSH;
    push_data = 16'h5555;
    #1;
    checks++;
    if (op_ready !== 1'b0) begin
      errors++;
      $display("FAIL swap2_ready: ready=%b, want 0", op_ready);
    end
    check_we("swap2_write", 1'b1, 13'd0, 16'hBBBB);
    step();
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL swap_ready_back: ready=%b, want 1", op_ready);
    end
    check_st("swap_state", 14'd2, 16'hAAAA, 16'hBBBB, 1'b0, 1'b0);
    drive(CLR, 16'h0); step();
  endtask

  task automatic test_underflow();
    drive(POP, 16'h0);
    check_we("uf_no_write", 1'b0, 13'd0, 16'h0);
    step();
    check_st("uf_state", 14'd0, 16'h0, 16'h0, 1'b0, 1'b1);
    drive(CLR, 16'h0); step();
    check_st("uf_clr", 14'd0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 4; i++) begin
      drive(PUSH, 16'h0100 + 16'(i)); step();
    end
    drive(PUSH, 16'h0104);
    check_we("of_no_write", 1'b0, 13'd0, 16'h0);
    step();
    check_st("of_state", 14'd4, 16'h0103, 16'h0102, 1'b1, 1'b0);
    drive(POP, 16'h0); step();
    check_st("of_pop", 14'd3, 16'h0102, 16'h0101, 1'b1, 1'b0);
    drive(CLR, 16'h0); step();
  endtask

  task automatic test_reset_swap();
    drive(POP, 16'h0); step();
    drive(PUSH, 16'h0C0C); step();
    drive(PUSH, 16'h0D0D); step();
    drive(SWAP, 16'h0); step();
    checks++;
    if (op_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_swap_pre: ready=%b, want 0", op_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (depth !== 14'd0 || op_ready !== 1'b1 ||
        err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_swap: depth=%0d ready=%b ov=%b un=%b, want 0 1 0 0",
               depth, op_ready, err_overflow, err_underflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

`ifdef STACK_CTRL_HIWATER_EN
  task automatic test_hiwater();
    checks++;
    if (hiwater !== 14'd0) begin
      errors++;
      $display("FAIL hw_reset: hiwater=%0d, want 0", hiwater);
    end
    drive(PUSH, 16'h1); step();
    drive(PUSH, 16'h2); step();
    drive(POP, 16'h0); step();
    checks++;
    if (hiwater !== 14'd2) begin
      errors++;
      $display("FAIL hw_peak: hiwater=%0d, want 2", hiwater);
    end
    drive(CLR, 16'h0); step();
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << WIDTH); i++) mem[i] = 16'h0;
    test_reset();
    test_push();
    test_binop();
    test_swap();
    test_underflow();
    test_overflow();
    test_reset_swap();
`ifdef STACK_CTRL_HIWATER_EN
    test_hiwater();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
